mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single multi-cycle, pipelined main memory between the instruction-side (I) and data-side (D) cache controllers of the 5-stage CPU.
- Arbitrates requests and sequences a full cache-block fill: BLOCK_WORDS sequential word reads, returned in order.
- Also sequences single-word D-side writes.
- Sits between the IF/MEM-stage cache controllers and main memory. While a requester's `done` is pending, the pipeline stalls through IF_ID_Write and the stall logic.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width; one word = 2 bytes.
- BLOCK_WORDS, 8, words per cache block (power of 2).
- MEM_LAT, 4, cycles from a mem_en read issue to the matching mem_rvalid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  I-side fill request; held until i_done.
- i_addr  in  ADDR_W  I-side miss address.
- i_grant  out  1  one-cycle pulse: I request accepted.
- i_fill_valid  out  1  fill_data is a word of the I fill.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_req  in  1  D-side request; held until d_done.
- d_we  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  ADDR_W  D-side address.
- d_wdata  in  DATA_W  D-side write data.
- d_grant  out  1  one-cycle pulse: D request accepted.
- d_fill_valid  out  1  fill_data is a word of the D fill.
- d_done  out  1  one-cycle pulse: D transaction complete.
- fill_data  out  DATA_W  returned word; equals mem_rdata.
- fill_idx  out  log2(BLOCK_WORDS)  index of the returned word within the block.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  write when mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid.
- mem_rvalid  in  1  read data valid.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset:** one clock, clk; rst_n is asynchronous and active-low. On reset:
  - state = IDLE; issue and receive counters = 0; owner = none.
  - Every output is 0, including mem_addr, mem_wdata and fill_idx.
  - Main memory shares rst_n, so no reads are in flight after reset.
  - Reset mid-fill abandons the fill; no done is issued.
- **States:** IDLE, ISSUE, DRAIN, WRITE, DONE.
- **IDLE, arbitration:** requests are sampled in IDLE only.
  - D has fixed priority over I; a D miss is the older instruction.
  - The winner's grant pulses combinationally in the same cycle T.
  - At T the arbiter latches owner, block base = addr with its low log2(2*BLOCK_WORDS) bits cleared, d_wdata and d_we.
  - Next state: WRITE if D with d_we = 1, else ISSUE.
- **ISSUE:** runs from T+1 to T+BLOCK_WORDS.
  - Each cycle: mem_en = 1, mem_wr = 0, mem_addr = base + 2*k, for k = 0..BLOCK_WORDS-1.
  - After the last issue, go to DRAIN.
- **Read returns:** accepted while in ISSUE or DRAIN.
  - Each mem_rvalid: fill_data = mem_rdata and fill_idx = receive count, both combinational.
  - The owner's *_fill_valid = 1; receive count increments.
  - mem_rvalid in IDLE, WRITE or DONE is ignored, and no fill_valid is raised.
  - Returns beyond BLOCK_WORDS are ignored; the counter saturates.
- **DRAIN:** when the BLOCK_WORDS-th word arrives (cycle T+BLOCK_WORDS+MEM_LAT), go to DONE.
- **WRITE:** one cycle: mem_en = 1, mem_wr = 1, mem_addr = latched d_addr (not block-aligned), mem_wdata = latched d_wdata. Then go to DONE.
- **DONE:** owner's *_done = 1 for one cycle; requests are ignored this cycle (turnaround); then go to IDLE.
  - The requester must drop req in the cycle after done, or it is re-granted as a new request.
- **Latency:**
  - Fill: grant at T, done at T+BLOCK_WORDS+MEM_LAT+1, i.e. T+13 with defaults.
  - Write: grant at T, d_done at T+2.
- **Non-preemptive:** a D request arriving during an I fill waits until IDLE.
- **Simultaneous i_req and d_req in IDLE:** D wins unless ARB_RR_EN is defined.
- **Outputs during transactions:**
  - mem_en = 0 in IDLE, DRAIN and DONE.
  - mem_addr and mem_wdata hold their last driven values when mem_en = 0.
  - Grants never pulse outside IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- **When defined:** a 1-bit last_owner flop (reset value I) is updated at each grant. When both request in IDLE, the side that was not last granted wins, giving alternation under contention.
- **When undefined:** fixed D-over-I priority; last_owner is not built.

Decomposition:
- **Package cpu_mem_pkg:**
  - state enum (IDLE, ISSUE, DRAIN, WRITE, DONE) and owner enum (NONE, I, D).
  - Default constants for ADDR_W, DATA_W, BLOCK_WORDS, MEM_LAT.
  - Block offset mask function.
- **Sub-module mem_arb_pick:** combinational request picker (fixed or round-robin) producing grant_i, grant_d and sel. Counters and the FSM stay in mem_arbiter.

Test Plan:
- **I fill:** i_req at cycle 0 with i_addr = 0x1236.
  - i_grant at 0; mem_en on cycles 1–8 with addr 0x1230, 0x1232 … 0x123E.
  - i_fill_valid with fill_idx 0..7 on cycles 5–12; i_done at 13; busy low at 14.
- **D write:** d_req = 1, d_we = 1, d_addr = 0x4002, d_wdata = 0xBEEF.
  - d_grant at 0; cycle 1: mem_en = 1, mem_wr = 1, addr 0x4002, data 0xBEEF; d_done at 2.
- **Contention:** i_req and d_req (fill, 0x8000) both high at cycle 0.
  - d_grant first; i_grant at cycle 14, the first IDLE after d_done.
  - With ARB_RR_EN, a repeated tie grants I then D alternately.
- **Reset mid-fill:** rst_n low at cycle 6 of an I fill.
  - All outputs 0 immediately; i_done never pulses; a new i_req after release gets a fresh 0..7 sequence.
- **Stray rvalid:** mem_rvalid = 1 while in IDLE → no fill_valid and no state change.
- **Held request:** requester keeps i_req high through DONE → re-granted exactly one cycle after DONE (IDLE), not during DONE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the I/D main-memory arbiter.
// Contents: FSM state enum, transaction owner enum, default widths/latency,
// and the block-offset mask helper used to align fill addresses.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned BLOCK_WORDS_DEF = 8;
  localparam int unsigned MEM_LAT_DEF     = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Byte-offset bits inside a block: one word is two bytes.
  function automatic logic [31:0] offset_mask(input int unsigned block_words);
    return 32'(2 * block_words - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and main-memory bus of the arbiter.
// slave  : arbiter side (takes requests and read data, drives grants/fill/mem cmd)
// master : requester + memory side
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W      = cpu_mem_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W      = cpu_mem_pkg::DATA_W_DEF,
  parameter int unsigned BLOCK_WORDS = cpu_mem_pkg::BLOCK_WORDS_DEF
);
  localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_fill_valid;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_fill_valid;
  logic              d_done;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_idx;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done,
           fill_data, fill_idx, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done,
           fill_data, fill_idx, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational request picker for the memory arbiter.
// Ports: enable (arbiter idle), i_req, d_req, [last_d], grant_i, grant_d, sel.
// Build option ARB_RR_EN: ties alternate using last_d (1 = D granted last);
// otherwise D always wins a tie.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic   enable,
  input  logic   i_req,
  input  logic   d_req,
`ifdef ARB_RR_EN
  input  logic   last_d,
`endif
  output logic   grant_i,
  output logic   grant_d,
  output owner_t sel
);

  logic pick_d;

  // Decide which side wins; only meaningful when some request is present.
  always_comb begin
    pick_d = d_req;
`ifdef ARB_RR_EN
    if (d_req && i_req) pick_d = ~last_d;
`endif
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    sel     = OWN_NONE;
    if (enable && (i_req || d_req)) begin
      if (pick_d) begin
        grant_d = 1'b1;
        sel     = OWN_D;
      end else begin
        grant_i = 1'b1;
        sel     = OWN_I;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between the I- and D-side cache controllers: sequences
// BLOCK_WORDS-word block fills (pipelined reads, in-order returns) and
// single-word D writes.
// Ports: clk, rst_n (async, active low), bus (mem_arbiter_if.slave: requests,
// grants, fill return, memory command/read data), busy (not idle).
// Build option ARB_RR_EN: round-robin tie breaking instead of D priority.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(offset_mask(BLOCK_WORDS));

  state_t            state;
  owner_t            owner;
  owner_t            sel;
  logic              grant_i;
  logic              grant_d;
  logic [IDX_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              last_word;
`ifdef ARB_RR_EN
  logic              last_d;
`endif

  mem_arb_pick u_pick (
    .enable  (state == S_IDLE),
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
`ifdef ARB_RR_EN
    .last_d  (last_d),
`endif
    .grant_i (grant_i),
    .grant_d (grant_d),
    .sel     (sel)
  );

  // Read returns count only while a fill is outstanding and not yet complete.
  assign accept    = ((state == S_ISSUE) || (state == S_DRAIN)) && bus.mem_rvalid
                     && (recv_cnt < CNT_W'(BLOCK_WORDS));
  assign last_word = accept && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

  // FSM, counters and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= OWN_NONE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      if (accept) recv_cnt <= recv_cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (grant_i || grant_d) begin
            owner     <= sel;
            issue_cnt <= '0;
            recv_cnt  <= '0;
`ifdef ARB_RR_EN
            last_d    <= grant_d;
`endif
            if (grant_d && bus.d_we) begin
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
              state   <= S_WRITE;
            end else begin
              addr_q  <= (grant_d ? bus.d_addr : bus.i_addr) & BASE_MASK;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Address stays on the last word so it holds once issuing stops.
          if (issue_cnt == IDX_W'(BLOCK_WORDS - 1)) begin
            state <= S_DRAIN;
          end else begin
            issue_cnt <= issue_cnt + IDX_W'(1);
            addr_q    <= addr_q + ADDR_W'(2);
          end
        end
        S_DRAIN: if (last_word) state <= S_DONE;
        S_WRITE: state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.i_grant      = grant_i;
  assign bus.d_grant      = grant_d;
  assign bus.i_fill_valid = accept && (owner == OWN_I);
  assign bus.d_fill_valid = accept && (owner == OWN_D);
  assign bus.fill_data    = accept ? bus.mem_rdata : '0;
  assign bus.fill_idx     = recv_cnt[IDX_W-1:0];
  assign bus.i_done       = (state == S_DONE) && (owner == OWN_I);
  assign bus.d_done       = (state == S_DONE) && (owner == OWN_D);
  assign bus.mem_en       = (state == S_ISSUE) || (state == S_WRITE);
  assign bus.mem_wr       = (state == S_WRITE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency pipelined memory model.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int unsigned LAT = MEM_LAT_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  // Memory model: read issued in cycle t returns in cycle t+LAT.
  logic        pipe_v [LAT];
  logic [15:0] pipe_d [LAT];
  logic        stray_v = 1'b0;
  logic [15:0] stray_d = 16'h0;

  function automatic logic [15:0] rd_of(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_d[k] <= 16'h0;
      end
    end else begin
      pipe_v[0] <= bus.mem_en && !bus.mem_wr;
      pipe_d[0] <= rd_of(bus.mem_addr);
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign bus.mem_rvalid = pipe_v[LAT-1] | stray_v;
  assign bus.mem_rdata  = pipe_v[LAT-1] ? pipe_d[LAT-1] : (stray_v ? stray_d : 16'h0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wdata = 16'h0;
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  // Walks cycles 0..13 of a fill whose grant cycle is the next negedge.
  task automatic fill_check(input bit own_d, input logic [15:0] base, input bit drop);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check("grant", own_d ? bus.d_grant : bus.i_grant, 32'(c == 0));
      check("other_grant", own_d ? bus.i_grant : bus.d_grant, 0);
      check("mem_en", bus.mem_en, 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        check("mem_wr", bus.mem_wr, 0);
        check("mem_addr", bus.mem_addr, 32'(16'(base + 16'(2 * (c - 1)))));
      end
      check("fill_valid", own_d ? bus.d_fill_valid : bus.i_fill_valid, 32'(c >= 5 && c <= 12));
      check("other_fill_valid", own_d ? bus.i_fill_valid : bus.d_fill_valid, 0);
      if (c >= 5 && c <= 12) begin
        check("fill_idx", bus.fill_idx, 32'(c - 5));
        check("fill_data", bus.fill_data, 32'(rd_of(16'(base + 16'(2 * (c - 5))))));
      end
      check("done", own_d ? bus.d_done : bus.i_done, 32'(c == 13));
      check("other_done", own_d ? bus.i_done : bus.d_done, 0);
      check("busy", busy, 32'(c != 0));
      if (c == 13 && drop) begin
        if (own_d) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_wr"}, bus.mem_wr, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_fill_idx"}, bus.fill_idx, 0);
    check({tag, "_fill_data"}, bus.fill_data, 0);
    check({tag, "_i_fv"}, bus.i_fill_valid, 0);
    check({tag, "_i_done"}, bus.i_done, 0);
    check({tag, "_d_done"}, bus.d_done, 0);
    check({tag, "_grants"}, {bus.i_grant, bus.d_grant}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // I fill from an unaligned miss address.
    start_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    fill_check(1'b0, 16'h1230, 1'b1);
    @(negedge clk);
    check("i_fill_idle_busy", busy, 0);

    // D single-word write.
    start_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h4002; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    check("wr_grant", bus.d_grant, 1);
    check("wr_c0_mem_en", bus.mem_en, 0);
    @(negedge clk);
    check("wr_mem_en", bus.mem_en, 1);
    check("wr_mem_wr", bus.mem_wr, 1);
    check("wr_mem_addr", bus.mem_addr, 32'h4002);
    check("wr_mem_wdata", bus.mem_wdata, 32'hBEEF);
    check("wr_c1_done", bus.d_done, 0);
    @(negedge clk);
    check("wr_done", bus.d_done, 1);
    check("wr_c2_mem_en", bus.mem_en, 0);
    check("wr_hold_addr", bus.mem_addr, 32'h4002);
    check("wr_hold_wdata", bus.mem_wdata, 32'hBEEF);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    check("wr_idle_busy", busy, 0);
    check("wr_no_regrant", bus.d_grant, 0);

    // Contention: D fill wins, I is granted at the first idle cycle after.
    start_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h8000;
    fill_check(1'b1, 16'h8000, 1'b1);
    fill_check(1'b0, 16'h0010, 1'b1);
    @(negedge clk);
    check("cont_idle_busy", busy, 0);

    // Stray read data while idle is ignored.
    start_cycle();
    stray_v = 1'b1; stray_d = 16'h1111;
    @(negedge clk);
    check("stray_i_fv", bus.i_fill_valid, 0);
    check("stray_d_fv", bus.d_fill_valid, 0);
    check("stray_busy", busy, 0);
    start_cycle();
    stray_v = 1'b0;
    @(negedge clk);
    check("stray_after_busy", busy, 0);

    // Held request is re-granted in the idle cycle after done, not during it.
    start_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h0A42;
    fill_check(1'b0, 16'h0A40, 1'b0);
    fill_check(1'b0, 16'h0A40, 1'b1);
    @(negedge clk);
    check("held_idle_busy", busy, 0);

    // Reset in the middle of an I fill, then a clean restart.
    start_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h2008;
    for (int c = 0; c < 6; c++) start_cycle();
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_i_done", bus.i_done, 0);
      check("midrst_mem_en", bus.mem_en, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_i_fv", bus.i_fill_valid, 0);
    start_cycle();
    bus.i_req = 1'b1; bus.i_addr = 16'h2008;
    fill_check(1'b0, 16'h2000, 1'b1);
    @(negedge clk);
    check("restart_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
